// File: rtl/dm_responder.sv
// Fixed-latency single-port data memory responder.
// Accepts a read or write request, stalls for LATENCY cycles, then pulses rdy.
module dm_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rdy,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                op_we_q, op_we_d;
    logic [15:0]         rd_data_q, rd_data_d;
    logic                rdy_q, rdy_d;
    logic                mem_we;

    logic [15:0]         mem [2**ADDR_W];

    // Upper address bits alias onto the implemented depth.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_we_d   = op_we_q;
        rd_data_d = rd_data_q;
        rdy_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (re | we) begin
                    addr_d  = addr[ADDR_W-1:0];
                    wdata_d = wrt_data;
                    op_we_d = we;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    if (op_we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_data_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            op_we_q   <= 1'b0;
            rd_data_q <= 16'h0000;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_we_q   <= op_we_d;
            rd_data_q <= rd_data_d;
            rdy_q     <= rdy_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rd_data = rd_data_q;
    assign rdy     = rdy_q;
    assign stall   = ((state_q == IDLE) & (re | we)) | (state_q == BUSY);

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=4 and LATENCY=1 instances.
module tb_dm_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr4, wd4, rd4, addr1, wd1, rd1;
    logic        re4, we4, rdy4, stall4;
    logic        re1, we1, rdy1, stall1;

    int checks = 0;
    int errors = 0;

    dm_responder #(.LATENCY(4), .ADDR_W(10)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr4),
        .re       (re4),
        .we       (we4),
        .wrt_data (wd4),
        .rd_data  (rd4),
        .rdy      (rdy4),
        .stall    (stall4)
    );

    dm_responder #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr1),
        .re       (re1),
        .we       (we1),
        .wrt_data (wd1),
        .rd_data  (rd1),
        .rdy      (rdy1),
        .stall    (stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (s) begin
            re1 = r; we1 = w; addr1 = a; wd1 = d;
        end else begin
            re4 = r; we4 = w; addr4 = a; wd4 = d;
        end
    endtask

    // Called at a negedge; returns cycles to rdy, stalled cycles, rd_data at rdy.
    task automatic acc(input bit s, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input bit mid, output int lat, output int nst,
                       output logic [15:0] rdv);
        lat = -1;
        nst = 0;
        rdv = 16'h0000;
        drive(s, r, w, a, d);
        #1;
        if (s ? stall1 : stall4) nst++;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (s ? stall1 : stall4) nst++;
            if (s ? rdy1 : rdy4) begin
                lat = i + 1;
                rdv = s ? rd1 : rd4;
            end
            if (mid && i == 0) drive(s, r, w, 16'h0007, 16'hFFFF);
        end
        drive(s, 1'b0, 1'b0, a, d);
        @(negedge clk);
        check("rdy_one_cycle", s ? rdy1 : rdy4, 0);
    endtask

    int          lat, nst;
    logic [15:0] rv;
    logic [4:0]  sv, yv;
    logic [15:0] ra, rb;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 16'h0, 16'h0);
        #1;
        check("rst_rd_data", rd4, 16'h0000);
        check("rst_rdy", rdy4, 0);
        check("rst_stall", stall4, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        acc(0, 0, 1, 16'h0005, 16'hBEEF, 0, lat, nst, rv);
        check("wr_beef_lat", lat, 5);
        check("wr_beef_stall", nst, 5);
        acc(0, 1, 0, 16'h0005, 16'h0000, 0, lat, nst, rv);
        check("rd_beef_lat", lat, 5);
        check("rd_beef", rv, 16'hBEEF);

        repeat (3) @(negedge clk);
        check("idle_rd_hold", rd4, 16'hBEEF);
        check("idle_rdy", rdy4, 0);
        check("idle_stall", stall4, 0);

        acc(0, 1, 1, 16'h0010, 16'h1234, 0, lat, nst, rv);
        check("rw_lat", lat, 5);
        check("rw_rd_hold", rv, 16'hBEEF);
        acc(0, 1, 0, 16'h0010, 16'h0000, 0, lat, nst, rv);
        check("rd_1234", rv, 16'h1234);

        acc(0, 0, 1, 16'h0403, 16'hA5A5, 0, lat, nst, rv);
        acc(0, 1, 0, 16'h0003, 16'h0000, 0, lat, nst, rv);
        check("alias_a5a5", rv, 16'hA5A5);

        acc(0, 0, 1, 16'h0007, 16'h0BAD, 0, lat, nst, rv);
        acc(0, 0, 1, 16'h0006, 16'h0042, 1, lat, nst, rv);
        check("mid_lat", lat, 5);
        acc(0, 1, 0, 16'h0006, 16'h0000, 0, lat, nst, rv);
        check("mid_a6", rv, 16'h0042);
        acc(0, 1, 0, 16'h0007, 16'h0000, 0, lat, nst, rv);
        check("mid_a7", rv, 16'h0BAD);

        acc(0, 0, 1, 16'h0020, 16'h1111, 0, lat, nst, rv);
        acc(0, 1, 0, 16'h0020, 16'h0000, 0, lat, nst, rv);
        check("pre_rst_rd", rv, 16'h1111);

        drive(0, 0, 1, 16'h0020, 16'h7777);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0020, 16'h7777);
        #1;
        check("abort_rd_data", rd4, 16'h0000);
        check("abort_rdy", rdy4, 0);
        check("abort_stall", stall4, 0);
        re4 = 1'b1;
        #1;
        check("rst_stall_re", stall4, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rdy", rdy4, 0);
        check("rel_stall", stall4, 1);
        re4 = 1'b0;
        @(negedge clk);
        acc(0, 1, 0, 16'h0020, 16'h0000, 0, lat, nst, rv);
        check("persist_20", rv, 16'h1111);

        acc(1, 0, 1, 16'h0001, 16'h0101, 0, lat, nst, rv);
        check("l1_wr_lat", lat, 2);
        check("l1_wr_stall", nst, 2);
        acc(1, 0, 1, 16'h0002, 16'h0202, 0, lat, nst, rv);

        sv = '0;
        yv = '0;
        ra = '0;
        rb = '0;
        drive(1, 1, 0, 16'h0001, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sv[i] = stall1;
            yv[i] = rdy1;
            if (i == 1) begin
                ra = rd1;
                addr1 = 16'h0002;
            end
            if (i == 4) rb = rd1;
        end
        drive(1, 0, 0, 16'h0000, 16'h0000);
        check("b2b_stall", sv, 5'b01101);
        check("b2b_rdy", yv, 5'b10010);
        check("b2b_rd1", ra, 16'h0101);
        check("b2b_rd2", rb, 16'h0202);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
